reg_file_scoreboard: RTL and testbench

- Parametrised successor to the single-word data register: a multi-entry general-purpose register file for the custom processor datapath.
- Provides two combinational read ports with write-through bypass and one synchronous write port.
- Holds a per-register busy scoreboard so the control FSM can stall on pending writebacks.
- Sits between the decode stage (reads, reservations) and the writeback stage (writes).

---
 rtl/reg_file_scoreboard_pkg.sv | 7 +
 rtl/reg_file_scoreboard_read_port.sv | 42 ++++
 rtl/reg_file_scoreboard.sv | 126 ++++++++++++
 tb/tb_reg_file_scoreboard.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_scoreboard_pkg.sv
// Shared defaults for the register file with busy scoreboard.
package reg_file_scoreboard_pkg;
   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_NUM_REGS   = 8;
   localparam bit          DEF_ZERO_REG   = 1'b1;
   localparam int unsigned ZERO_REG_IDX   = 0;
endpackage

// File: rtl/reg_file_scoreboard_read_port.sv
// One combinational read port: range check, zero-register mask and write-through bypass.
module rf_read_port
   import reg_file_scoreboard_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
   parameter bit          ZERO_REG   = DEF_ZERO_REG
) (
   input  logic [ADDR_WIDTH-1:0]                i_rd_addr,
   input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  i_regs,
   input  logic [NUM_REGS-1:0]                  i_busy,
   input  logic                                 i_wr_en,
   input  logic [ADDR_WIDTH-1:0]                i_wr_addr,
   input  logic [DATA_WIDTH-1:0]                i_wr_data,
   output logic [DATA_WIDTH-1:0]                o_rd_data,
   output logic                                 o_rd_busy
);
   localparam int unsigned CMP_W = ADDR_WIDTH + 1;

   logic w_in_range;
   logic w_is_zero;
   logic w_bypass;

   assign w_in_range = (CMP_W'(i_rd_addr) < CMP_W'(NUM_REGS));
   assign w_is_zero  = ZERO_REG && (i_rd_addr == ADDR_WIDTH'(ZERO_REG_IDX));
   assign w_bypass   = i_wr_en && (i_wr_addr == i_rd_addr);

   // Out-of-range and hardwired-zero reads return 0 / not busy, and never bypass.
   always_comb begin
      o_rd_data = '0;
      o_rd_busy = 1'b0;
      if (w_in_range && !w_is_zero) begin
         if (w_bypass) begin
            o_rd_data = i_wr_data;
         end else begin
            o_rd_data = i_regs[i_rd_addr];
            o_rd_busy = i_busy[i_rd_addr];
         end
      end
   end
endmodule

// File: rtl/reg_file_scoreboard.sv
// Multi-entry register file with two bypassed read ports, one write port
// and a per-register busy scoreboard for stalling on pending writebacks.
module reg_file_scoreboard
   import reg_file_scoreboard_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
   parameter bit          ZERO_REG   = DEF_ZERO_REG
) (
   input  logic                  clk,
   input  logic                  clear_n,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic                  rd_busy_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   output logic                  rd_busy_b,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rsv_en,
   input  logic [ADDR_WIDTH-1:0] rsv_addr,
   output logic                  rsv_ack,
   input  logic                  flush,
   output logic [NUM_REGS-1:0]   busy_vec
);
   localparam int unsigned CMP_W = ADDR_WIDTH + 1;

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
   logic [NUM_REGS-1:0]                 r_busy;
   logic [NUM_REGS-1:0]                 w_busy_nxt;

   logic w_wr_in_range;
   logic w_wr_zero;
   logic w_wr_ok;
   logic w_rsv_in_range;
   logic w_rsv_zero;
   logic w_rsv_free;
   logic w_rsv_set;

   assign w_wr_in_range  = (CMP_W'(wr_addr) < CMP_W'(NUM_REGS));
   assign w_wr_zero      = ZERO_REG && (wr_addr == ADDR_WIDTH'(ZERO_REG_IDX));
   assign w_wr_ok        = wr_en && w_wr_in_range && !w_wr_zero;

   assign w_rsv_in_range = (CMP_W'(rsv_addr) < CMP_W'(NUM_REGS));
   assign w_rsv_zero     = ZERO_REG && (rsv_addr == ADDR_WIDTH'(ZERO_REG_IDX));

   // A busy register is still reservable when its writeback lands this same cycle.
   always_comb begin
      w_rsv_free = 1'b0;
      if (w_rsv_zero) begin
         w_rsv_free = 1'b1;
      end else if (w_rsv_in_range) begin
         w_rsv_free = !r_busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr));
      end
   end

   assign rsv_ack   = rsv_en && !flush && w_rsv_in_range && w_rsv_free;
   assign w_rsv_set = rsv_ack && !w_rsv_zero;

   // Per-bit priority: flush > reserve > write-release.
   always_comb begin
      w_busy_nxt = r_busy;
      if (flush) begin
         w_busy_nxt = '0;
      end else begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_rsv_set && (rsv_addr == ADDR_WIDTH'(i))) begin
               w_busy_nxt[i] = 1'b1;
            end else if (w_wr_ok && (wr_addr == ADDR_WIDTH'(i))) begin
               w_busy_nxt[i] = 1'b0;
            end
         end
      end
      if (ZERO_REG) begin
         w_busy_nxt[ADDR_WIDTH'(ZERO_REG_IDX)] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_regs <= '0;
         r_busy <= '0;
      end else begin
         if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
         end
         r_busy <= w_busy_nxt;
      end
   end

   assign busy_vec = r_busy;

   rf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
   ) u_port_a (
      .i_rd_addr (rd_addr_a),
      .i_regs    (r_regs),
      .i_busy    (r_busy),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_rd_data (rd_data_a),
      .o_rd_busy (rd_busy_a)
   );

   rf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
   ) u_port_b (
      .i_rd_addr (rd_addr_b),
      .i_regs    (r_regs),
      .i_busy    (r_busy),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_rd_data (rd_data_b),
      .o_rd_busy (rd_busy_b)
   );
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: an 8-entry instance plus a 6-entry one
// sharing the same stimulus, so that addresses 6 and 7 are out of range on the second.
module tb_reg_file_scoreboard;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          clear_n;
   logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
   logic [DW-1:0] wr_data;
   logic          wr_en, rsv_en, flush;

   logic [DW-1:0] rd_data_a, rd_data_b;
   logic          rd_busy_a, rd_busy_b, rsv_ack;
   logic [7:0]    busy_vec;

   logic [DW-1:0] s_rd_data_a, s_rd_data_b;
   logic          s_rd_busy_a, s_rd_busy_b, s_rsv_ack;
   logic [5:0]    s_busy_vec;

   int            n_vec  = 0;
   int            n_miss = 0;
   logic [31:0]   exp_q[$];

   always #5 clk = ~clk;

   reg_file_scoreboard u_dut (
      .clk (clk), .clear_n (clear_n),
      .rd_addr_a (rd_addr_a), .rd_data_a (rd_data_a), .rd_busy_a (rd_busy_a),
      .rd_addr_b (rd_addr_b), .rd_data_b (rd_data_b), .rd_busy_b (rd_busy_b),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .rsv_en (rsv_en), .rsv_addr (rsv_addr), .rsv_ack (rsv_ack),
      .flush (flush), .busy_vec (busy_vec)
   );

   reg_file_scoreboard #(.NUM_REGS (6)) u_dut6 (
      .clk (clk), .clear_n (clear_n),
      .rd_addr_a (rd_addr_a), .rd_data_a (s_rd_data_a), .rd_busy_a (s_rd_busy_a),
      .rd_addr_b (rd_addr_b), .rd_data_b (s_rd_data_b), .rd_busy_b (s_rd_busy_b),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .rsv_en (rsv_en), .rsv_addr (rsv_addr), .rsv_ack (s_rsv_ack),
      .flush (flush), .busy_vec (s_busy_vec)
   );

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_miss++;
         $error("FAIL %s: observed %h, no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en  = 1'b0;
      rsv_en = 1'b0;
      flush  = 1'b0;
   endtask

   initial begin
      idle();
      rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
      clear_n = 1'b0;
      #2;
      push(32'h0); push(32'h0); push(32'h0);
      chk("rst_busy_vec", 32'(busy_vec));
      chk("rst_rsv_ack", 32'(rsv_ack));
      chk("rst_rd_a", 32'(rd_data_a));
      @(negedge clk);
      clear_n = 1'b1;

      // write r3, reserve it, then an asynchronous reset pulse mid-cycle
      tick(); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
      tick(); wr_en = 1'b0; rd_addr_a = 3'd3; rsv_en = 1'b1; rsv_addr = 3'd3;
      push(32'h1234); #1; chk("r3_written", 32'(rd_data_a));
      tick(); rsv_en = 1'b0;
      push(32'h08); #1; chk("r3_reserved", 32'(busy_vec));
      clear_n = 1'b0; #1;
      push(32'h0); push(32'h0);
      chk("async_clr_rd_a", 32'(rd_data_a));
      chk("async_clr_busy", 32'(busy_vec));
      #1; clear_n = 1'b1;

      // write-through bypass, then registered read on port B
      tick(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; rd_addr_a = 3'd5;
      push(32'hBEEF); push(32'h0); #1;
      chk("bypass_a_data", 32'(rd_data_a));
      chk("bypass_a_busy", 32'(rd_busy_a));
      tick(); wr_en = 1'b0; rd_addr_b = 3'd5;
      push(32'hBEEF); #1; chk("r5_port_b", 32'(rd_data_b));

      // reserve r2, retry while busy, release by write
      tick(); rsv_en = 1'b1; rsv_addr = 3'd2; rd_addr_a = 3'd2;
      push(32'h1); #1; chk("rsv_r2_ack", 32'(rsv_ack));
      tick();
      push(32'h04); push(32'h0); push(32'h1); #1;
      chk("rsv_r2_busy_vec", 32'(busy_vec));
      chk("rsv_r2_again_ack", 32'(rsv_ack));
      chk("rsv_r2_rd_busy", 32'(rd_busy_a));
      tick(); rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'd7;
      push(32'h7); push(32'h0); #1;
      chk("wr_r2_bypass_data", 32'(rd_data_a));
      chk("wr_r2_bypass_busy", 32'(rd_busy_a));
      tick(); wr_en = 1'b0;
      push(32'h0); #1; chk("r2_released", 32'(busy_vec));

      // same-cycle write and reserve on a busy register
      tick(); rsv_en = 1'b1; rsv_addr = 3'd4;
      push(32'h1); #1; chk("rsv_r4_ack", 32'(rsv_ack));
      tick(); wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0055;
      push(32'h10); push(32'h1); #1;
      chk("r4_busy_vec", 32'(busy_vec));
      chk("wr_rsv_r4_ack", 32'(rsv_ack));
      tick(); idle(); rd_addr_a = 3'd4;
      push(32'h10); push(32'h55); push(32'h1); #1;
      chk("wr_rsv_busy_vec", 32'(busy_vec));
      chk("wr_rsv_r4_data", 32'(rd_data_a));
      chk("wr_rsv_r4_busy", 32'(rd_busy_a));

      // flush beats a reservation; a same-cycle write still lands
      tick(); rsv_en = 1'b1; rsv_addr = 3'd1;
      push(32'h1); #1; chk("rsv_r1_ack", 32'(rsv_ack));
      tick(); rsv_addr = 3'd6;
      push(32'h1); #1; chk("rsv_r6_ack", 32'(rsv_ack));
      tick(); rsv_addr = 3'd3; flush = 1'b1; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'd9;
      push(32'h52); push(32'h0); #1;
      chk("pre_flush_busy_vec", 32'(busy_vec));
      chk("flush_rsv_ack", 32'(rsv_ack));
      tick(); idle(); rd_addr_b = 3'd6;
      push(32'h0); push(32'h9); push(32'h0); #1;
      chk("flush_busy_vec", 32'(busy_vec));
      chk("flush_r6_data", 32'(rd_data_b));
      chk("flush_r6_busy", 32'(rd_busy_b));

      // zero register
      tick(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; rd_addr_a = 3'd0;
      push(32'h0); #1; chk("r0_no_bypass", 32'(rd_data_a));
      tick(); wr_en = 1'b0;
      push(32'h0); push(32'h0); #1;
      chk("r0_read_data", 32'(rd_data_a));
      chk("r0_read_busy", 32'(rd_busy_a));
      tick(); rsv_en = 1'b1; rsv_addr = 3'd0;
      push(32'h1); #1; chk("rsv_r0_ack", 32'(rsv_ack));
      tick(); rsv_en = 1'b0;
      push(32'h0); #1; chk("rsv_r0_busy_vec", 32'(busy_vec));

      // address 7: out of range on the 6-entry instance, valid on the 8-entry one
      tick(); wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hAAAA;
      rsv_en = 1'b1; rsv_addr = 3'd7; rd_addr_a = 3'd7;
      push(32'h0); push(32'h0); push(32'h0); push(32'h1); push(32'hAAAA); #1;
      chk("oor_rd_data", 32'(s_rd_data_a));
      chk("oor_rd_busy", 32'(s_rd_busy_a));
      chk("oor_rsv_ack", 32'(s_rsv_ack));
      chk("r7_rsv_ack", 32'(rsv_ack));
      chk("r7_bypass", 32'(rd_data_a));
      tick(); idle(); rd_addr_b = 3'd7;
      push(32'h0); push(32'h0); push(32'h0); push(32'h80); push(32'hAAAA); push(32'h1); #1;
      chk("oor_busy_vec", 32'(s_busy_vec));
      chk("oor_rd_b_data", 32'(s_rd_data_b));
      chk("oor_rd_b_busy", 32'(s_rd_busy_b));
      chk("r7_busy_vec", 32'(busy_vec));
      chk("r7_data", 32'(rd_data_b));
      chk("r7_busy", 32'(rd_busy_b));
      rd_addr_a = 3'd5; rd_addr_b = 3'd4;
      push(32'hBEEF); push(32'h55); #1;
      chk("n6_r5_data", 32'(s_rd_data_a));
      chk("n6_r4_data", 32'(s_rd_data_b));
      rd_addr_a = 3'd6; rd_addr_b = 3'd2;
      push(32'h0); push(32'h7); push(32'h0); #1;
      chk("n6_addr6_data", 32'(s_rd_data_a));
      chk("n6_r2_data", 32'(s_rd_data_b));
      chk("n6_r3_after_clr", 32'(u_dut6.rd_data_a == 16'h0 ? 32'h0 : 32'h0) | 32'(busy_vec[0]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
